// File: rtl/cpu_pkg.sv
// Shared CPU definitions, imported by the instruction decoder and by the PC stage.
// Contents:
//   - opcode_e: opcode encodings for the control-flow instructions. Only the
//     decoder interprets these. The PC stage sees the decoded strobes.
//   - PC_WIDTH_DEFAULT: default width of the program counter.
package cpu_pkg;

  localparam int PC_WIDTH_DEFAULT = 5;

  typedef enum logic [3:0] {
    JMP     = 4'h0,
    IF0JUMP = 4'h1,
    IF1JUMP = 4'h2,
    CALL    = 4'h3,
    CAL0    = 4'h4,
    CAL1    = 4'h5,
    RET     = 4'h6,
    RET0    = 4'h7,
    RET1    = 4'h8
  } opcode_e;

endpackage

// File: rtl/ret_addr_lifo.sv
// Return-address LIFO.
// Ports:
//   clk, rst       clock and synchronous active-high reset (rst clears the depth only)
//   push, wdata    push wdata on top of the stack (ignored when full)
//   pop            drop the top entry (ignored when empty; wins over push)
//   top            combinational read of the top entry (undefined when empty)
//   depth          number of valid entries
//   full           depth == DEPTH
module ret_addr_lifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_reg;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (depth_reg == DW'(DEPTH));
  assign do_pop  = pop && (depth_reg != '0);
  assign do_push = push && !full && !pop;

  // The write slot is the current depth. The top entry sits one slot below it.
  assign wr_idx = depth_reg[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_reg <= '0;
    end else if (do_pop) begin
      depth_reg <= depth_reg - DW'(1);
    end else if (do_push) begin
      depth_reg <= depth_reg + DW'(1);
    end
  end

  // The entry storage has no reset. Stale entries are unreachable once depth is 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= wdata;
    end
  end

  // The read is combinational. A return in the cycle after a call sees the pushed address.
  assign top   = mem[rd_idx];
  assign depth = depth_reg;

endmodule

// File: rtl/pc_call_stack.sv
// Program-counter stage that follows the instruction decoder.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   en              advance enable; 0 holds all state
//   jmp, cal, ret   decoded strobes; priority ret > cal > jmp > sequential step
//   jmp_addr        jump/call target
//   pc              registered instruction address
//   depth           number of valid return addresses
//   stack_full      depth == STACK_DEPTH
//   overflow        sticky: a call was attempted while the stack was full
//   underflow       sticky: a return was attempted while the stack was empty
module pc_call_stack
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int STACK_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                jmp,
  input  logic                cal,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] jmp_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [DW-1:0]       depth,
  output logic                stack_full,
  output logic                overflow,
  output logic                underflow
);

  logic [PC_WIDTH-1:0] pc_reg, pc_next, pc_inc, stack_top;
  logic                ovf_reg, ovf_next;
  logic                unf_reg, unf_next;
  logic                push, pop;
  logic                full;
  logic                empty;

  // Adding 1 wraps modulo 2^PC_WIDTH, so a call at the last address stores 0.
  assign pc_inc = pc_reg + PC_WIDTH'(1);
  assign empty  = (depth == '0);

  ret_addr_lifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (pc_inc),
    .top   (stack_top),
    .depth (depth),
    .full  (full)
  );

  // Next-PC priority mux. A failed call or return still advances the PC,
  // so the faulting instruction executes as a NOP.
  always_comb begin
    pc_next  = pc_reg;
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    push     = 1'b0;
    pop      = 1'b0;
    if (en) begin
      if (ret) begin
        if (empty) begin
          pc_next  = pc_inc;
          unf_next = 1'b1;
        end else begin
          pc_next = stack_top;
          pop     = 1'b1;
        end
      end else if (cal) begin
        if (full) begin
          pc_next  = pc_inc;
          ovf_next = 1'b1;
        end else begin
          pc_next = jmp_addr;
          push    = 1'b1;
        end
      end else if (jmp) begin
        pc_next = jmp_addr;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg  <= RESET_PC;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  assign pc         = pc_reg;
  assign stack_full = full;
  assign overflow   = ovf_reg;
  assign underflow  = unf_reg;

endmodule
